// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the sweep/run state encoding and the default geometry constants.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Per-register write resolution: for each register, whether any port writes it
// this cycle and which data wins (highest-indexed port).
// Ports: wr_en_i/wr_addr_i/wr_data_i (packed per port) in;
//        hit_o (one bit per register), data_o (XLEN per register) out.
module rf_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*AW-1:0]     wr_addr_i,
    input  logic [NWR*XLEN-1:0]   wr_data_i,
    output logic [NREGS-1:0]      hit_o,
    output logic [NREGS*XLEN-1:0] data_o
);

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        hit_o  = '0;
        data_o = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                hit_o[int'(wr_addr_i[j*AW +: AW])] = 1'b1;
                data_o[int'(wr_addr_i[j*AW +: AW])*XLEN +: XLEN] =
                    wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, a pending scoreboard and a
// post-reset zero sweep. Ports: clk_i, rst_i; rd_addr_i/rd_data_o/rd_busy_o per
// read port; wr_en_i/wr_addr_i/wr_data_i per write port; issue_en_i/issue_rd_i
// mark a destination pending; init_busy_o is high while the sweep runs.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic                init_busy_o
);

    rf_state_e         state_q, state_d;
    logic [AW-1:0]     sweep_cnt_q, sweep_cnt_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic [NREGS-1:0]      mem_we;
    logic [NREGS*XLEN-1:0] mem_wd;
    logic [NREGS-1:0]      wr_hit;
    logic [NREGS*XLEN-1:0] wr_sel;
    logic                  run;

    rf_wr_arbiter #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_arb (
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .hit_o     (wr_hit),
        .data_o    (wr_sel)
    );

    assign run         = (state_q == ST_RUN) && !rst_i;
    assign init_busy_o = rst_i || (state_q != ST_RUN);

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        if (rst_i) begin
            state_d     = ST_INIT;
            sweep_cnt_d = '0;
        end else if (state_q != ST_RUN) begin
            sweep_cnt_d = sweep_cnt_q + AW'(1);
            if (sweep_cnt_q == AW'(NREGS - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Array write enables: sweep zeroes one register per cycle; in RUN the
    // arbiter result drives writes, with x0 never stored.
    always_comb begin
        mem_we = '0;
        mem_wd = '0;
        if (run) begin
            mem_we    = wr_hit;
            mem_we[0] = 1'b0;
            mem_wd    = wr_sel;
        end else if (!rst_i) begin
            mem_we[int'(sweep_cnt_q)] = 1'b1;
        end
    end

    // Write clears first, then issue sets, so a same-cycle issue wins.
    always_comb begin
        pending_d = '0;
        if (run) begin
            pending_d = pending_q & ~wr_hit;
            if (issue_en_i) begin
                pending_d[int'(issue_rd_i)] = 1'b1;
            end
            pending_d[0] = 1'b0;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        if (run) begin
            for (int k = 0; k < NRD; k++) begin
                automatic int a = int'(rd_addr_i[k*AW +: AW]);
                if (a == 0) begin
                    rd_data_o[k*XLEN +: XLEN] = '0;
                    rd_busy_o[k]              = 1'b0;
                end else if (wr_hit[a]) begin
                    rd_data_o[k*XLEN +: XLEN] = wr_sel[a*XLEN +: XLEN];
                    rd_busy_o[k]              = 1'b0;
                end else begin
                    rd_data_o[k*XLEN +: XLEN] = mem_q[a];
                    rd_busy_o[k]              = pending_q[a];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            pending_q   <= pending_d;
        end
    end

    // No reset on the array: contents come only from the sweep and writes.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NREGS; r++) begin
            if (mem_we[r]) begin
                mem_q[r] <= mem_wd[r*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
// Inputs change 1ns after a rising edge; combinational outputs checked 1ns later.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2*AW-1:0]   rd_addr_i;
    logic [2*XLEN-1:0] rd_data_o;
    logic [1:0]        rd_busy_o;
    logic [1:0]        wr_en_i;
    logic [2*AW-1:0]   wr_addr_i;
    logic [2*XLEN-1:0] wr_data_i;
    logic              issue_en_i;
    logic [AW-1:0]     issue_rd_i;
    logic              init_busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_busy_o   (rd_busy_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .issue_en_i  (issue_en_i),
        .issue_rd_i  (issue_rd_i),
        .init_busy_o (init_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    task automatic idle();
        wr_en_i    = 2'b00;
        issue_en_i = 1'b0;
    endtask

    function automatic logic [31:0] d0();
        return rd_data_o[XLEN-1:0];
    endfunction

    function automatic logic [31:0] d1();
        return rd_data_o[2*XLEN-1:XLEN];
    endfunction

    // Counts init_busy_o high cycles from now, bounded.
    task automatic count_init(output int n);
        n = 0;
        while (init_busy_o && n < 200) begin
            n++;
            tick();
            wr_en_i = 2'b00;
        end
    endtask

    int n;

    initial begin
        rst_i      = 1'b1;
        rd_addr_i  = '0;
        wr_en_i    = '0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        issue_en_i = 1'b0;
        issue_rd_i = '0;
        rd(5'd3, 5'd4);
        settle();
        chk("rst_busy", 32'(init_busy_o), 32'd1);
        chk("rst_rdata0", d0(), 32'd0);
        chk("rst_rbusy", 32'(rd_busy_o), 32'd0);
        tick();
        rst_i = 1'b0;
        // Writes and issue during the sweep must be dropped.
        wr_en_i    = 2'b01;
        wr_addr_i  = {5'd0, 5'd3};
        wr_data_i  = {32'd0, 32'hDEAD};
        issue_en_i = 1'b1;
        issue_rd_i = 5'd4;
        settle();
        chk("init_rdata", d0(), 32'd0);
        idle();
        count_init(n);
        chk("init_len", 32'(n), 32'd32);

        for (int r = 0; r < NREGS; r += 2) begin
            rd(5'(r), 5'(r + 1));
            settle();
            chk("zero_p0", d0(), 32'd0);
            chk("zero_p1", d1(), 32'd0);
            chk("zero_busy", 32'(rd_busy_o), 32'd0);
        end

        // Dual write collision on x5.
        wr_en_i   = 2'b11;
        wr_addr_i = {5'd5, 5'd5};
        wr_data_i = {32'h22, 32'h11};
        rd(5'd5, 5'd5);
        settle();
        chk("coll_byp", d0(), 32'h22);
        chk("coll_byp1", d1(), 32'h22);
        tick();
        idle();
        settle();
        chk("coll_arr", d0(), 32'h22);

        // Port 1 alone, different addresses on both ports.
        wr_en_i   = 2'b10;
        wr_addr_i = {5'd6, 5'd0};
        wr_data_i = {32'h6666, 32'h0};
        rd(5'd6, 5'd5);
        settle();
        chk("p1_byp", d0(), 32'h6666);
        chk("p1_other", d1(), 32'h22);
        tick();
        idle();

        // Scoreboard on x7.
        issue_en_i = 1'b1;
        issue_rd_i = 5'd7;
        rd(5'd7, 5'd7);
        settle();
        chk("iss_same", 32'(rd_busy_o), 32'd0);
        tick();
        idle();
        settle();
        chk("sb_busy", 32'(rd_busy_o), 32'd3);
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd7};
        wr_data_i = {32'd0, 32'hABCD};
        settle();
        chk("sb_wr_busy", 32'(rd_busy_o), 32'd0);
        chk("sb_wr_data", d0(), 32'hABCD);
        tick();
        idle();
        settle();
        chk("sb_clr", 32'(rd_busy_o), 32'd0);
        chk("sb_arr", d1(), 32'hABCD);

        // Issue/write race on x9.
        issue_en_i = 1'b1;
        issue_rd_i = 5'd9;
        wr_en_i    = 2'b10;
        wr_addr_i  = {5'd9, 5'd0};
        wr_data_i  = {32'h5, 32'd0};
        rd(5'd9, 5'd9);
        tick();
        idle();
        settle();
        chk("race_busy", 32'(rd_busy_o), 32'd3);
        chk("race_data", d0(), 32'h5);

        // x0 ignores writes and issue.
        wr_en_i    = 2'b01;
        wr_addr_i  = {5'd0, 5'd0};
        wr_data_i  = {32'd0, 32'hFFFFFFFF};
        issue_en_i = 1'b1;
        issue_rd_i = 5'd0;
        rd(5'd0, 5'd9);
        settle();
        chk("x0_byp", d0(), 32'd0);
        chk("x0_busy_same", 32'(rd_busy_o[0]), 32'd0);
        tick();
        idle();
        settle();
        chk("x0_data", d0(), 32'd0);
        chk("x0_busy", 32'(rd_busy_o[0]), 32'd0);

        // Saturating pending on x10.
        issue_en_i = 1'b1;
        issue_rd_i = 5'd10;
        rd(5'd10, 5'd9);
        tick();
        tick();
        idle();
        settle();
        chk("sat_busy", 32'(rd_busy_o[0]), 32'd1);
        wr_en_i   = 2'b01;
        wr_addr_i = {5'd0, 5'd10};
        wr_data_i = {32'd0, 32'h1234};
        tick();
        idle();
        settle();
        chk("sat_clr", 32'(rd_busy_o[0]), 32'd0);
        chk("sat_data", d0(), 32'h1234);

        // Mid-sweep reset: sweep restarts and drops writes during INIT.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy", 32'(init_busy_o), 32'd1);
        rst_i = 1'b1;
        settle();
        chk("mid_rst_rbusy", 32'(rd_busy_o), 32'd0);
        tick();
        rst_i     = 1'b0;
        wr_en_i   = 2'b11;
        wr_addr_i = {5'd5, 5'd5};
        wr_data_i = {32'h77, 32'h77};
        count_init(n);
        chk("mid_len", 32'(n), 32'd32);
        idle();
        rd(5'd5, 5'd10);
        settle();
        chk("mid_x5", d0(), 32'd0);
        chk("mid_x10", d1(), 32'd0);
        rd(5'd9, 5'd7);
        settle();
        chk("mid_pend", 32'(rd_busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width; NREGS, default 32, register count (power of 2, >=4); NRD, default 2, read ports; NWR, default 2, write ports; AW = clog2(NREGS), derived.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- rd_addr_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data_o  out  NRD*XLEN  read data, combinational.
- rd_busy_o  out  NRD  register has an outstanding producer.
- wr_en_i  in  NWR  write enables.
- wr_addr_i  in  NWR*AW  write addresses.
- wr_data_i  in  NWR*XLEN  write data.
- issue_en_i  in  1  mark destination pending.
- issue_rd_i  in  AW  destination register being issued.
- init_busy_o  out  1  post-reset clearing sweep in progress.

Function
REQ-003 The FSM SHALL have two states: INIT (zero-clearing sweep) and RUN.
REQ-004 In INIT, each cycle SHALL write zero to reg[sweep_cnt] and increment sweep_cnt by 1.
REQ-005 The FSM SHALL go INIT->RUN on the cycle sweep_cnt==NREGS-1 is written; the sweep SHALL take exactly NREGS cycles after rst_i falls.
REQ-006 init_busy_o SHALL be 1 exactly while in INIT.
REQ-007 In INIT: wr_en_i and issue_en_i ignored; rd_data_o=0; rd_busy_o=0.
REQ-008 RUN writes: when wr_en_i[j] is set, reg[wr_addr_j] SHALL take wr_data_j at the next rising edge.
REQ-009 Ports writing the same address in one cycle: the highest-indexed port SHALL win.
REQ-010 Register 0 SHALL read 0, ignore writes, never be pending, and never be bypassed.
REQ-011 Read port k SHALL be combinational, zero-latency, write-first: an enabled write to rd_addr_k this cycle (highest port per REQ-009) SHALL drive rd_data_k; otherwise the array value.
REQ-012 The scoreboard SHALL hold one pending bit per register.
REQ-013 issue_en_i in RUN SHALL set pending[issue_rd_i] at the next edge; issue_rd_i==0 has no effect.
REQ-014 Any enabled write to address a SHALL clear pending[a] at the next edge.
REQ-015 Same cycle issue and write to one register: issue SHALL win (pending=1 after the edge); the write data still SHALL be stored.
REQ-016 rd_busy_o[k] SHALL equal pending[rd_addr_k] AND NOT (enabled write to rd_addr_k this cycle); bypassed data is valid.
REQ-017 Pending bits SHALL saturate: repeated issues keep the bit at 1; one write clears it.
REQ-018 The block SHALL not generate X on outputs for any in-range address.

Reset
REQ-019 While rst_i=1, next state SHALL be INIT, sweep_cnt=0, all pending bits=0.
REQ-020 While rst_i=1, outputs SHALL be init_busy_o=1, rd_data_o=0, rd_busy_o=0.
REQ-021 Array contents SHALL be defined only by the INIT sweep, not by rst_i directly, so the array maps to RAM/flops without a reset net.
REQ-022 rst_i asserted mid-sweep or mid-RUN SHALL restart the full sweep from sweep_cnt=0.

Structure
REQ-023 A shared package regfile_pkg SHALL hold the state enum (INIT, RUN) and default XLEN/NREGS constants.
REQ-024 Sub-module rf_wr_arbiter SHALL resolve per-address winning write port and data (used by write, bypass and scoreboard clear); all else inline.

Verification
REQ-025 Reset: rst_i 1 cycle then 0 -> init_busy_o high exactly 32 cycles; all 32 registers read 0 afterward.
REQ-026 Dual write collision: port0 writes x5<=0x11, port1 writes x5<=0x22 same cycle -> same-cycle read of x5 gives 0x22; next cycle also 0x22.
REQ-027 Scoreboard: issue x7; next cycle rd_busy=1 on x7; write x7=0xABCD -> same cycle rd_busy=0 with data 0xABCD; following cycle pending=0.
REQ-028 Issue/write race: issue x9 and write x9=0x5 same cycle -> next cycle rd_busy=1, data 0x5.
REQ-029 x0: write 0xFFFFFFFF and issue x0 -> reads 0, rd_busy=0.
REQ-030 Mid-sweep reset: rst_i at sweep cycle 10 -> sweep restarts; init_busy_o high 32 cycles after release; writes during INIT dropped.
